// File: rtl/branch_router_fifo_pkg.sv
// Shared definitions for the instruction decoder, the branch router and the
// per-branch execution units: default geometry and the payload field layout.
package branch_router_fifo_pkg;

  localparam int N_INSTR_BRANCHES = 4;
  localparam int INSTR_FIFO_DEPTH = 4;

  localparam int BLOCK_W   = 8;
  localparam int OP_W      = 8;
  localparam int ARGS_W    = 64;
  localparam int ACC_W     = 32;
  localparam int COMMIT_W  = 12;
  localparam int FLAGS_W   = 4;
  localparam int INSTR_PAYLOAD_W = BLOCK_W + OP_W + ARGS_W + ACC_W + COMMIT_W + FLAGS_W;

  // Field order matches the decoder's packing, MSB first.
  typedef struct packed {
    logic [BLOCK_W-1:0]  block;
    logic [OP_W-1:0]     op;
    logic [ARGS_W-1:0]   args;
    logic [ACC_W-1:0]    acc;
    logic [COMMIT_W-1:0] commit_id;
    logic [FLAGS_W-1:0]  flags;
  } instr_payload_t;

  function automatic logic [INSTR_PAYLOAD_W-1:0] pack_payload(input instr_payload_t p);
    return INSTR_PAYLOAD_W'(p);
  endfunction

  function automatic instr_payload_t unpack_payload(input logic [INSTR_PAYLOAD_W-1:0] v);
    return instr_payload_t'(v);
  endfunction

endpackage

// File: rtl/branch_router_fifo_branch_fifo.sv
// Single-clock FIFO for one execution branch. Head is read straight out of the
// storage registers, so it is stable for as long as the entry is not popped.
module branch_fifo
  import branch_router_fifo_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = INSTR_PAYLOAD_W,
  parameter int DEPTH         = INSTR_FIFO_DEPTH,
  parameter int LVL_W         = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PAYLOAD_WIDTH-1:0] push_data,
  output logic                     full,
  output logic                     empty,
  output logic [LVL_W-1:0]         level,
  output logic [PAYLOAD_WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];
  logic                     clear;
  logic                     do_push;
  logic                     do_pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign head  = mem_q[rd_ptr_q];

  // Reset and flush override any push/pop presented in the same cycle.
  assign clear   = reset | (enable & flush);
  assign do_push = ~clear & enable & push & ~full;
  assign do_pop  = ~clear & enable & pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
  end

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/branch_router_fifo.sv
// Routes one decoded instruction payload per cycle into per-branch FIFOs,
// broadcasting atomically when the branch mask has more than one bit set.
module branch_router_fifo
  import branch_router_fifo_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = INSTR_PAYLOAD_W,
  parameter int N_BRANCHES    = N_INSTR_BRANCHES,
  parameter int DEPTH         = INSTR_FIFO_DEPTH,
  parameter int LVL_W         = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]            in_payload,
  input  logic [N_BRANCHES-1:0]               in_branch_mask,
  output logic [N_BRANCHES-1:0]               out_valid,
  input  logic [N_BRANCHES-1:0]               out_ready,
  output logic [N_BRANCHES*PAYLOAD_WIDTH-1:0] out_payload,
  output logic [N_BRANCHES*LVL_W-1:0]         level,
  output logic                                empty_mask_err
);

  logic [N_BRANCHES-1:0] full;
  logic [N_BRANCHES-1:0] empty;
  logic [N_BRANCHES-1:0] push;
  logic [N_BRANCHES-1:0] pop;
  logic                  take_in;
  logic                  err_q, err_d;

  // Uses only registered full flags, so a same-cycle pop on a full target
  // still blocks the input; out_ready never reaches in_ready.
  always_comb begin
    in_ready = enable & ~flush;
    for (int i = 0; i < N_BRANCHES; i++) begin
      if (in_branch_mask[i] && full[i]) in_ready = 1'b0;
    end
  end

  assign take_in   = in_valid & in_ready;
  assign push      = {N_BRANCHES{take_in}} & in_branch_mask;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready & {N_BRANCHES{enable}};

  always_comb begin
    err_d = take_in & ~(|in_branch_mask);
    if (reset || (enable && flush)) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    err_q <= err_d;
  end

  assign empty_mask_err = err_q;

  for (genvar g = 0; g < N_BRANCHES; g++) begin : g_branch
    branch_fifo #(
      .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
      .DEPTH         (DEPTH),
      .LVL_W         (LVL_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .flush     (flush),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_data (in_payload),
      .full      (full[g]),
      .empty     (empty[g]),
      .level     (level[g*LVL_W +: LVL_W]),
      .head      (out_payload[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH])
    );
  end

endmodule

// File: tb/tb_branch_router_fifo.sv
// Directed and randomized bench for branch_router_fifo, checked every cycle
// against a queue-per-branch reference model.
module tb_branch_router_fifo;

  localparam int PW = 128;
  localparam int NB = 4;
  localparam int D  = 4;
  localparam int LW = $clog2(D) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              fl;
  logic              vld;
  logic              in_ready;
  logic [PW-1:0]     pl;
  logic [NB-1:0]     msk;
  logic [NB-1:0]     out_valid;
  logic [NB-1:0]     ordy;
  logic [NB*PW-1:0]  out_payload;
  logic [NB*LW-1:0]  level;
  logic              empty_mask_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [PW-1:0] mq [NB][$];
  logic          err_exp = 1'b0;

  branch_router_fifo #(
    .PAYLOAD_WIDTH (PW),
    .N_BRANCHES    (NB),
    .DEPTH         (D),
    .LVL_W         (LW)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .enable         (en),
    .flush          (fl),
    .in_valid       (vld),
    .in_ready       (in_ready),
    .in_payload     (pl),
    .in_branch_mask (msk),
    .out_valid      (out_valid),
    .out_ready      (ordy),
    .out_payload    (out_payload),
    .level          (level),
    .empty_mask_err (empty_mask_err)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lvl(input int i);
    return level[i*LW +: LW];
  endfunction

  function automatic logic [PW-1:0] head(input int i);
    return out_payload[i*PW +: PW];
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the registered outputs with the model, one check per item.
  task automatic check_state();
    logic [NB-1:0] exp_v;
    for (int i = 0; i < NB; i++) exp_v[i] = (mq[i].size() > 0);
    chk("out_valid", PW'(out_valid), PW'(exp_v));
    chk("empty_mask_err", PW'(empty_mask_err), PW'(err_exp));
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("level[%0d]", i), PW'(lvl(i)), PW'(mq[i].size()));
      if (mq[i].size() > 0) chk($sformatf("head[%0d]", i), head(i), mq[i][0]);
    end
  endtask

  // Inputs are already driven; check, clock once, advance the model.
  task automatic step();
    logic exp_rdy;
    logic take;
    #1;
    exp_rdy = en && !fl;
    for (int i = 0; i < NB; i++) if (msk[i] && mq[i].size() == D) exp_rdy = 1'b0;
    chk("in_ready", PW'(in_ready), PW'(exp_rdy));
    check_state();
    take = vld && exp_rdy;
    @(posedge clk);
    if (rst || (en && fl)) begin
      for (int i = 0; i < NB; i++) mq[i].delete();
      err_exp = 1'b0;
    end else begin
      for (int i = 0; i < NB; i++) if (en && ordy[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (take) for (int i = 0; i < NB; i++) if (msk[i]) mq[i].push_back(pl);
      err_exp = take && (msk == '0);
    end
    #1;
  endtask

  task automatic cycx(input logic v, input logic [NB-1:0] m, input logic [PW-1:0] p,
                      input logic [NB-1:0] r, input logic e, input logic f, input logic rs);
    vld = v; msk = m; pl = p; ordy = r; en = e; fl = f; rst = rs;
    step();
  endtask

  task automatic cyc(input logic v, input logic [NB-1:0] m, input logic [PW-1:0] p,
                     input logic [NB-1:0] r);
    cycx(v, m, p, r, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [NB-1:0] rm;
    logic [PW-1:0] rp;
    rst = 1'b1; en = 1'b1; fl = 1'b0; vld = 1'b0; msk = '0; pl = '0; ordy = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 4'b0000, '0, 4'b0000);
    chk("rst_level", PW'(level), '0);
    chk("rst_out_valid", PW'(out_valid), '0);

    // 1: single push and pop on branch 1
    cyc(1, 4'b0010, PW'(8'hA5), 4'b0000);
    chk("t1_valid", PW'(out_valid), PW'(4'b0010));
    chk("t1_head", head(1), PW'(8'hA5));
    chk("t1_level", PW'(lvl(1)), PW'(1));
    cyc(0, 4'b0000, '0, 4'b0010);
    chk("t1_pop_level", PW'(lvl(1)), '0);
    chk("t1_pop_valid", PW'(out_valid), '0);

    // 2: branch 0 stalls, branch 2 keeps flowing
    for (int k = 1; k <= 5; k++) cyc(1, 4'b0001, PW'(k), 4'b0000);
    chk("t2_full_level", PW'(lvl(0)), PW'(D));
    chk("t2_head0", head(0), PW'(1));
    for (int k = 0; k < 6; k++) cyc(1, 4'b0100, PW'(16'h200 + k), 4'b0100);
    cyc(0, 4'b0000, '0, 4'b0100);
    chk("t2_b2_drained", PW'(lvl(2)), '0);
    chk("t2_b0_held", PW'(lvl(0)), PW'(D));

    // 3: broadcast blocked by full branch 3
    cycx(0, 4'b0000, '0, 4'b0000, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < D; k++) cyc(1, 4'b1000, PW'(16'h300 + k), 4'b0000);
    cyc(1, 4'b1011, PW'(16'hBBBB), 4'b0000);
    chk("t3_blocked_l0", PW'(lvl(0)), '0);
    chk("t3_blocked_l1", PW'(lvl(1)), '0);
    cyc(1, 4'b1011, PW'(16'hBBBB), 4'b1000);
    cyc(1, 4'b1011, PW'(16'hBBBB), 4'b0000);
    chk("t3_l0", PW'(lvl(0)), PW'(1));
    chk("t3_l1", PW'(lvl(1)), PW'(1));
    chk("t3_l2", PW'(lvl(2)), '0);
    chk("t3_l3", PW'(lvl(3)), PW'(D));
    chk("t3_head0", head(0), PW'(16'hBBBB));

    // 4: full-rate streaming through branch 2
    cycx(0, 4'b0000, '0, 4'b0000, 1'b1, 1'b0, 1'b1);
    cyc(1, 4'b0100, PW'(0), 4'b0000);
    for (int k = 1; k < 20; k++) begin
      chk("t4_seq", head(2), PW'(k - 1));
      chk("t4_level", PW'(lvl(2)), PW'(1));
      cyc(1, 4'b0100, PW'(k), 4'b0100);
    end
    chk("t4_seq_last", head(2), PW'(19));
    cyc(0, 4'b0000, '0, 4'b0100);
    chk("t4_empty", PW'(lvl(2)), '0);

    // 5: zero mask
    cyc(1, 4'b0000, PW'(16'hDEAD), 4'b0000);
    chk("t5_err_hi", PW'(empty_mask_err), PW'(1));
    cyc(0, 4'b0000, '0, 4'b0000);
    chk("t5_err_lo", PW'(empty_mask_err), '0);
    chk("t5_levels", PW'(level), '0);

    // 6: freeze, flush, mid-burst reset
    cyc(1, 4'b0011, PW'(16'h601), 4'b0000);
    cyc(1, 4'b0011, PW'(16'h602), 4'b0000);
    cyc(1, 4'b0010, PW'(16'h603), 4'b0000);
    cyc(1, 4'b1000, PW'(16'h604), 4'b0000);
    for (int k = 0; k < 3; k++) cycx(1, 4'b0001, PW'(16'h6F0), 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("t6_frz_l0", PW'(lvl(0)), PW'(2));
    chk("t6_frz_l1", PW'(lvl(1)), PW'(3));
    chk("t6_frz_l3", PW'(lvl(3)), PW'(1));
    cycx(1, 4'b0001, PW'(16'h6F1), 4'b0000, 1'b1, 1'b1, 1'b0);
    chk("t6_flush_level", PW'(level), '0);
    chk("t6_flush_valid", PW'(out_valid), '0);
    for (int k = 0; k < 3; k++) cyc(1, 4'b0101, PW'(16'h610 + k), 4'b0000);
    cycx(1, 4'b0101, PW'(16'h620), 4'b0000, 1'b1, 1'b0, 1'b1);
    chk("t6_rst_level", PW'(level), '0);
    chk("t6_rst_valid", PW'(out_valid), '0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0:       rm = '0;
        1, 2:    rm = NB'($urandom);
        default: rm = NB'(1) << $urandom_range(0, NB - 1);
      endcase
      rp = {$urandom, $urandom, $urandom, $urandom};
      cycx($urandom_range(0, 3) != 0, rm, rp, NB'($urandom),
           $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 199) == 0);
    end
    cyc(0, 4'b0000, '0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_router_fifo.md
Name: branch_router_fifo

Overview:
- Parametrised successor to the single-slot instruction branch router.
- Accepts one packed instruction payload per cycle and routes it to one or more of N_BRANCHES execution branches, selected by a branch mask. Multi-bit masks broadcast the payload.
- Each branch has its own DEPTH-entry FIFO, so a stalled branch never blocks traffic bound for other branches.
- Sits between the instruction decoder and the per-branch execution units.

Parameters:
- PAYLOAD_WIDTH, 128: width of packed payload (block, op, args, accumulator, commit id, flags).
- N_BRANCHES, 4: number of output branches.
- DEPTH, 4: entries per branch FIFO; power of two, ≥2.
- LVL_W, $clog2(DEPTH)+1: width of each per-branch occupancy count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global run gate; when low, all state is frozen.
- flush  in  1  synchronous clear of all FIFOs.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  router can accept the current payload.
- in_payload  in  PAYLOAD_WIDTH  payload.
- in_branch_mask  in  N_BRANCHES  target branches; one-hot normally, multi-hot for broadcast.
- out_valid  out  N_BRANCHES  per-branch head valid.
- out_ready  in  N_BRANCHES  per-branch consumer ready.
- out_payload  out  N_BRANCHES*PAYLOAD_WIDTH  per-branch head payload; branch i occupies bits [i*PW +: PW].
- level  out  N_BRANCHES*LVL_W  per-branch occupancy, 0..DEPTH.
- empty_mask_err  out  1  one-cycle pulse when a zero-mask payload is accepted.

Behaviour:
- Reset (reset=1) and flush (flush=1 with enable=1):
  - all FIFOs emptied: pointers=0, level=0.
  - out_valid=0, empty_mask_err=0.
  - Payload storage contents are not reset.
- Reset has priority over flush. Flush has priority over push and pop in the same cycle.
- Reset mid-stream drops all queued entries; there is no partial delivery.
- in_ready = enable & ~flush & AND over i of (~in_branch_mask[i] | ~full_i).
  - in_ready depends only on mask and registered full flags. There is no combinational path from out_ready to in_ready.
  - A FIFO that is full but popping in the same cycle still reports not-ready. This is deliberate and conservative.
- Accept (take_in = in_valid & in_ready): payload is written to every FIFO i with mask[i]=1, all in the same cycle. Broadcast is atomic: all targets are written or none.
- Zero mask: the payload is accepted (in_ready=enable&~flush), discarded, and empty_mask_err pulses high the next cycle.
- Pop (branch i): out_valid[i] & out_ready[i] & enable. Branches pop independently; any subset may pop in one cycle.
- Latency: an entry accepted at edge N gives out_valid[i]=1 after edge N; it is visible in the cycle after acceptance.
  - out_payload[i] is the registered FIFO head, stable while out_valid[i]=1 and not popped.
- Per-branch order is FIFO. There is no ordering guarantee across branches.
- Simultaneous push and pop on the same FIFO: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Full is level==DEPTH; empty is level==0.
- enable=0:
  - in_ready=0.
  - out_valid is held at its registered value but no pop occurs.
  - Pointers and levels are frozen.
  - Consumers must qualify out_ready with enable.
- level[i] is registered and updates on the same edge as the push/pop.

Decomposition:
- Shared header (instr_dec.vh/core.vh): N_INSTR_BRANCHES default, payload field offsets/widths, and pack/unpack macros used by the decoder and execution units.
- One sub-module: branch_fifo.
  - Single-clock, DEPTH×PAYLOAD_WIDTH, registered head.
  - Ports: push, pop, flush, full, empty, level, head.
  - Instantiated N_BRANCHES times via generate.
- Top level holds only the in_ready reduction, mask fan-out and error pulse.

Test Plan:
1. Reset then single push, mask=4'b0010, payload=0xA5 → out_valid=4'b0010 in the cycle after acceptance, out_payload[1]=0xA5, level[1]=1. Pop → level[1]=0, out_valid=0.
2. Branch 0 held with out_ready[0]=0, DEPTH=4: push 5 entries to mask 4'b0001 → in_ready drops after the 4th accept. Meanwhile pushes to mask 4'b0100 still accepted, and branch 2 drains normally.
3. Broadcast mask 4'b1011 while branch 3 is full → in_ready=0 and no FIFO is written. After one pop from branch 3, the payload is written to 0, 1 and 3 in the same cycle; each level increments by 1.
4. Continuous push+pop on branch 2 at full rate for 20 cycles with payloads 0..19 → output sequence 0..19 in order, level constant at 1.
5. Zero mask with in_valid=1 → accepted, empty_mask_err=1 for exactly one cycle, all levels unchanged.
6. FIFOs partly filled (levels 2,3,0,1): enable=0 for 3 cycles → no change to any level. Then flush=1 together with in_valid=1 → all levels 0, out_valid=0, the input is not accepted. Reset asserted mid-burst → same cleared state.
